shft_ctrl: RTL

SHFT_CTRL -- requirements
Module: shft_ctrl

---
 rtl/shft_ctrl_pkg.sv | 41 ++++
 rtl/shft_ctrl_step.sv | 43 ++++
 rtl/shft_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/shft_ctrl_pkg.sv
// ============================================================================
// shft_ctrl_pkg : op codes, FSM states and step helpers for the iterative shifter
// Revision 1.0
// ============================================================================
`default_nettype none

package shft_ctrl_pkg;

  localparam logic [1:0] CPU6_OP_SLL = 2'b00;
  localparam logic [1:0] CPU6_OP_SRL = 2'b01;
  localparam logic [1:0] CPU6_OP_SRA = 2'b10;
  localparam logic [1:0] CPU6_OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    CPU6_ST_IDLE  = 2'd0,
    CPU6_ST_SHIFT = 2'd1,
    CPU6_ST_DONE  = 2'd2
  } cpu6_state_t;

  localparam logic [1:0] CPU6_STEP_1  = 2'd0;
  localparam logic [1:0] CPU6_STEP_4  = 2'd1;
  localparam logic [1:0] CPU6_STEP_16 = 2'd2;

  // Largest step that does not overshoot the remaining distance.
  function automatic logic [1:0] cpu6_step_sel(input logic [4:0] rem);
    if (rem >= 5'd16)     return CPU6_STEP_16;
    else if (rem >= 5'd4) return CPU6_STEP_4;
    else                  return CPU6_STEP_1;
  endfunction

  function automatic logic [4:0] cpu6_step_size(input logic [1:0] sel);
    case (sel)
      CPU6_STEP_16: return 5'd16;
      CPU6_STEP_4:  return 5'd4;
      default:      return 5'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/shft_ctrl_step.sv
// ============================================================================
// shft_step : combinational single-step shifter (1, 4 or 16 bits, left/right)
// Revision 1.0
// ============================================================================
`default_nettype none

module shft_step
  import shft_ctrl_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_sel,
  input  logic        i_dir,   // 0: left, 1: right
  input  logic        i_fill,  // bit shifted in on right shifts
  output logic [31:0] o_res
);

  logic [31:0] w_left;
  logic [31:0] w_right;

  always_comb begin
    w_left  = i_data;
    w_right = i_data;
    case (i_sel)
      CPU6_STEP_16: begin
        w_left  = {i_data[15:0], 16'h0000};
        w_right = {{16{i_fill}}, i_data[31:16]};
      end
      CPU6_STEP_4: begin
        w_left  = {i_data[27:0], 4'h0};
        w_right = {{4{i_fill}}, i_data[31:4]};
      end
      default: begin
        w_left  = {i_data[30:0], 1'b0};
        w_right = {i_fill, i_data[31:1]};
      end
    endcase
  end

  assign o_res = i_dir ? w_right : w_left;

endmodule

`default_nettype wire

// File: rtl/shft_ctrl.sv
// ============================================================================
// shft_ctrl : multi-cycle SLL/SRL/SRA unit stepping 16/4/1 bits per cycle
// Revision 1.0
// ============================================================================
`default_nettype none

module shft_ctrl
  import shft_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  op,
  input  logic [31:0] src,
  input  logic [4:0]  shamt,
  input  logic        flush,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res
);

  cpu6_state_t r_state;
  logic [31:0] r_data;
  logic [4:0]  r_rem;
  logic [1:0]  r_op;
  logic        r_sign;
  logic [31:0] r_res;

  logic [1:0]  w_sel;
  logic [4:0]  w_rem_next;
  logic [31:0] w_step;
  logic        w_dir;
  logic        w_fill;

  assign w_sel      = cpu6_step_sel(r_rem);
  assign w_rem_next = r_rem - cpu6_step_size(w_sel);
  assign w_dir      = (r_op != CPU6_OP_SLL);
  assign w_fill     = (r_op == CPU6_OP_SRA) ? r_sign : 1'b0;

  shft_step u_step (
    .i_data (r_data),
    .i_sel  (w_sel),
    .i_dir  (w_dir),
    .i_fill (w_fill),
    .o_res  (w_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CPU6_ST_IDLE;
      r_data  <= 32'h0;
      r_rem   <= 5'd0;
      r_op    <= 2'b00;
      r_sign  <= 1'b0;
      r_res   <= 32'h0;
    end else if (flush) begin
      r_state <= CPU6_ST_IDLE;
    end else begin
      case (r_state)
        CPU6_ST_IDLE: begin
          if (req_valid) begin
            r_data  <= src;
            r_rem   <= shamt;
            r_op    <= op;
            r_sign  <= src[31];
            r_state <= (shamt != 5'd0 && op != CPU6_OP_RSV) ? CPU6_ST_SHIFT
                                                           : CPU6_ST_DONE;
          end
        end
        CPU6_ST_SHIFT: begin
          r_data <= w_step;
          r_rem  <= w_rem_next;
          if (w_rem_next == 5'd0) r_state <= CPU6_ST_DONE;
        end
        CPU6_ST_DONE: begin
          r_res   <= r_data;
          r_state <= CPU6_ST_IDLE;
        end
        default: r_state <= CPU6_ST_IDLE;
      endcase
    end
  end

  // The strobe is gated so a flush or reset landing in DONE kills it the same cycle.
  assign req_ready = (r_state == CPU6_ST_IDLE);
  assign busy      = (r_state != CPU6_ST_IDLE);
  assign res_valid = (r_state == CPU6_ST_DONE) && !flush && !reset;
  assign res       = res_valid ? r_data : r_res;

endmodule

`default_nettype wire
